// File: rtl/ring_writer.sv
// ring_writer: clears an external ring buffer, then streams one pattern into it and waits to settle.
// Defining RING_WRITER_DROP_CNT_EN adds drop_cnt, a saturating count of samples discarded after overflow.
module ring_writer #(
   parameter int DW         = 14,
   parameter int DEPTH      = 128,
   parameter int SETTLE_CYC = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] s_tdata,
   input  logic          s_tvalid,
   input  logic          s_tlast,
   output logic          s_tready,
   output logic          ring_rst,
   output logic [DW-1:0] ring_din,
   output logic          ring_wr_en,
   output logic          busy,
   output logic          loaded,
   output logic [7:0]    length,
   output logic          ovf
`ifdef RING_WRITER_DROP_CNT_EN
   ,
   output logic [15:0]   drop_cnt
`endif
);

   localparam int            SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [7:0]    DEPTH_W     = 8'(DEPTH);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DROP, SETTLE, DONE} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [7:0]    count;
   logic [SW-1:0] settle_cnt;
   logic          hs;

   assign hs = s_tvalid & s_tready;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = CLEAR;
         CLEAR:      state_nxt = LOAD;
         // s_tlast wins over reaching DEPTH, so an exact fill ends normally
         LOAD: if (hs) begin
            if (s_tlast)                        state_nxt = SETTLE;
            else if (count + 8'd1 == DEPTH_W)   state_nxt = DROP;
         end
         DROP:   if (hs && s_tlast)              state_nxt = SETTLE;
         SETTLE: if (settle_cnt == SETTLE_LAST)  state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         s_tready   <= 1'b0;
         ring_rst   <= 1'b0;
         ring_din   <= '0;
         ring_wr_en <= 1'b0;
         busy       <= 1'b0;
         loaded     <= 1'b0;
         length     <= '0;
         ovf        <= 1'b0;
         count      <= '0;
         settle_cnt <= '0;
`ifdef RING_WRITER_DROP_CNT_EN
         drop_cnt   <= '0;
`endif
      end else begin
         // outputs are decoded from the next state so they line up with it
         state      <= state_nxt;
         s_tready   <= (state_nxt == LOAD) || (state_nxt == DROP);
         busy       <= !((state_nxt == IDLE) || (state_nxt == DONE));
         loaded     <= (state_nxt == DONE);
         ring_rst   <= (state_nxt == CLEAR);
         ring_wr_en <= 1'b0;
         case (state)
            IDLE, DONE: if (start) begin
               count      <= '0;
               length     <= '0;
               ovf        <= 1'b0;
               settle_cnt <= '0;
`ifdef RING_WRITER_DROP_CNT_EN
               drop_cnt   <= '0;
`endif
            end
            LOAD: if (hs) begin
               ring_din   <= s_tdata;
               ring_wr_en <= 1'b1;
               count      <= count + 8'd1;
               if (s_tlast) begin
                  length <= count + 8'd1;
               end else if (count + 8'd1 == DEPTH_W) begin
                  length <= DEPTH_W;
                  ovf    <= 1'b1;
               end
            end
`ifdef RING_WRITER_DROP_CNT_EN
            DROP: if (hs && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;
`endif
            SETTLE: settle_cnt <= settle_cnt + SW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ring_writer.sv
// Scoreboard bench for ring_writer: expected ring writes are queued at issue time, a monitor pops them.
module tb_ring_writer;

   localparam int DW         = 14;
   localparam int DEPTH      = 128;
   localparam int SETTLE_CYC = 8;

   logic          clk      = 1'b0;
   logic          rst      = 1'b1;
   logic          start    = 1'b0;
   logic [DW-1:0] s_tdata  = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tlast  = 1'b0;
   logic          s_tready;
   logic          ring_rst;
   logic [DW-1:0] ring_din;
   logic          ring_wr_en;
   logic          busy;
   logic          loaded;
   logic [7:0]    length;
   logic          ovf;
`ifdef RING_WRITER_DROP_CNT_EN
   logic [15:0]   drop_cnt;
`endif

   int            checks         = 0;
   int            errors         = 0;
   int            rst_pulses     = 0;
   int            exp_rst_pulses = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] mon_exp;

   ring_writer #(.DW(DW), .DEPTH(DEPTH), .SETTLE_CYC(SETTLE_CYC)) dut (
      .clk(clk), .rst(rst), .start(start),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .ring_rst(ring_rst), .ring_din(ring_din), .ring_wr_en(ring_wr_en),
      .busy(busy), .loaded(loaded), .length(length), .ovf(ovf)
`ifdef RING_WRITER_DROP_CNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Monitor: every ring write must match the oldest outstanding expected sample
   initial begin
      forever begin
         @(negedge clk);
         if (ring_wr_en && ring_rst) check("wr_en_with_ring_rst", 1, 0);
         if (ring_rst) rst_pulses++;
         if (ring_wr_en) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ring_write", int'(ring_din), -1);
            end else begin
               mon_exp = exp_q.pop_front();
               check("ring_din", int'(ring_din), int'(mon_exp));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic beat(input logic [DW-1:0] d, input bit last, output int stall);
      stall    = 0;
      s_tdata  = d;
      s_tvalid = 1'b1;
      s_tlast  = last;
      @(negedge clk);
      while (!s_tready && stall < 50) begin
         @(negedge clk);
         stall++;
      end
      if (!s_tready) check("handshake_timeout", 0, 1);
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic do_start();
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      exp_rst_pulses++;
      @(negedge clk);
      check("start_ring_rst", int'(ring_rst), 1);
      check("start_loaded",   int'(loaded),   0);
      check("start_busy",     int'(busy),     1);
      check("start_length",   int'(length),   0);
      check("start_ovf",      int'(ovf),      0);
      check("start_tready",   int'(s_tready), 0);
   endtask

   // Reference: first min(n,DEPTH) samples land in the ring; anything beyond is overflow
   task automatic run_load(input int n, input int mode, input bit directed, input int start_at);
      logic [DW-1:0] d;
      int            stall;
      int            stalls = 0;
      int            k      = 0;
      for (int i = 0; i < n; i++) begin
         d = directed ? DW'(i + 1) : DW'($urandom);
         if (i < DEPTH) exp_q.push_back(d);
         if (i == start_at) start = 1'b1;
         beat(d, (i == n - 1), stall);
         start = 1'b0;
         stalls += stall;
         if (i != n - 1) begin
            if (mode == 1) begin
               @(posedge clk);
               #1;
            end else if (mode == 2 && $urandom_range(0, 3) == 0) begin
               repeat ($urandom_range(1, 3)) begin
                  @(posedge clk);
                  #1;
               end
            end
         end
      end
      check("tready_stalls", stalls, 0);
      do begin
         @(negedge clk);
         k++;
      end while (!loaded && k < SETTLE_CYC + 20);
      check("settle_latency", k, SETTLE_CYC + 1);
      check("done_loaded", int'(loaded), 1);
      check("done_busy", int'(busy), 0);
      check("done_tready", int'(s_tready), 0);
      check("length", int'(length), (n < DEPTH) ? n : DEPTH);
      check("ovf", int'(ovf), (n > DEPTH) ? 1 : 0);
      check("writes_outstanding", exp_q.size(), 0);
      check("ring_rst_pulses", rst_pulses, exp_rst_pulses);
`ifdef RING_WRITER_DROP_CNT_EN
      check("drop_cnt", int'(drop_cnt), (n > DEPTH) ? n - DEPTH : 0);
`endif
   endtask

   task automatic check_all_zero(input string name);
      logic [31:0] all;
      all = {16'd0, s_tready, ring_rst, ring_wr_en, busy, loaded, ovf, length} | 32'(ring_din);
`ifdef RING_WRITER_DROP_CNT_EN
      all = all | 32'(drop_cnt);
`endif
      check(name, int'(all), 0);
   endtask

   initial begin
      int stall;
      repeat (3) @(negedge clk);
      check_all_zero("reset_outputs");
      @(posedge clk);
      #1;
      rst = 1'b0;

      do_start();
      run_load(5, 0, 1'b1, -1);

      do_start();
      run_load(130, 0, 1'b0, -1);

      do_start();
      run_load(128, 0, 1'b0, -1);

      do_start();
      run_load(4, 1, 1'b0, -1);

      // start while loading must be ignored
      do_start();
      run_load(6, 0, 1'b0, 2);

      // reset with the third write still in flight
      do_start();
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(DW'(i + 100));
         beat(DW'(i + 100), 1'b0, stall);
      end
      check("inflight_writes", exp_q.size(), 1);
      rst = 1'b1;
      #1;
      check_all_zero("midload_reset_outputs");
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("post_reset_idle");

      do_start();
      run_load(1, 0, 1'b0, -1);
      do_start();
      run_load(129, 0, 1'b0, -1);

      for (int r = 0; r < 6; r++) begin
         do_start();
         run_load($urandom_range(1, 140), $urandom_range(0, 2), 1'b0, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
